sub4_serial: RTL and testbench
==============================

Name: sub4_serial

Overview:
Bit-serial WIDTH-bit subtractor with borrow: computes d = a - b - bi, one bit per clock, LSB first, using a single full-subtractor cell.
It is the inverse-direction companion to the team's 4-bit full-adder blocks and uses the same operand/carry port style (a, b, ci → here bi, bo).
A start/busy/done handshake lets a stimulus or control block issue operations and collect results.

Parameters:
WIDTH, 4, operand and result width in bits (≥2)

Ports:
clk    input   1      rising-edge clock
rst_n  input   1      asynchronous active-low reset
start  input   1      request; sampled only in IDLE or DONE
a      input   WIDTH  minuend, captured on accepted start
b      input   WIDTH  subtrahend, captured on accepted start
bi     input   1      borrow-in, captured on accepted start
d      output  WIDTH  difference; registered, held until next completion
bo     output  1      borrow-out; registered, held with d
busy   output  1      high in SHIFT state
done   output  1      one-cycle pulse when d/bo update

Behaviour:
- Reset (async, rst_n=0): state=IDLE; d=0, bo=0, busy=0, done=0; internal shift registers, borrow and counter cleared. Reset mid-operation aborts; no done pulse follows.
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 at edge → capture a→ra, b→rb, bi→br, cnt=0, go SHIFT.
- SHIFT (busy=1), each edge:
  - x = ra[0], y = rb[0]
  - diff = x^y^br
  - br ← (~x&y) | (~(x^y)&br)
  - ra, rb shift right; diff shifts into MSB of internal rd
  - cnt++
  - When cnt reaches WIDTH-1 on this edge: d ← final rd, bo ← final borrow, go DONE.
- DONE: done=1 for exactly this cycle. Next edge: start=1 → accept new operands, go SHIFT (back-to-back allowed); else go IDLE.
- Latency: start accepted at edge N → done high in the cycle after edge N+WIDTH. Throughput is one result per WIDTH+1 cycles.
- start during SHIFT is ignored; operands a/b/bi may change freely after capture without effect.
- d/bo change only on the DONE-entry edge; stable otherwise, including across IDLE.
- Arithmetic is modulo 2^WIDTH. bo=1 iff a < b + bi (unsigned).
- Counter width is clog2(WIDTH); no other wrap condition exists.

Optional Feature:
SUB_OVF_EN: when defined, adds output port ov (1 bit), registered and updated with d/bo.
- ov = signed two's-complement overflow: (a[MSB]≠b[MSB]) && (d[MSB]≠a[MSB]), using captured operands.
- Reset value of ov is 0.
- When not defined, the ov port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then a=9, b=3, bi=0, start 1 cycle → done pulse 4 cycles after start edge, d=6, bo=0, busy high for exactly 4 cycles.
- a=3, b=9, bi=1 → d=9 (3-9-1 = -7 mod 16), bo=1.
- a=0, b=0, bi=1 → d=15, bo=1. Then a=15, b=15, bi=0 → d=0, bo=0.
- Back-to-back: start held high with a=5,b=2,bi=0 then a=2,b=5,bi=0 captured on the DONE cycle → results d=3,bo=0 then d=13,bo=1. Done pulses are 5 cycles apart. A start pulse mid-SHIFT is ignored: no extra done, result unchanged.
- Reset asserted on the 2nd SHIFT cycle of a=12,b=4 → immediately d=0, bo=0, busy=0; no done pulse. Next operation a=12,b=4 gives d=8, bo=0.
- With SUB_OVF_EN: a=7, b=8, bi=0 → d=15, bo=1, ov=1. Then a=8, b=1 → d=7, bo=0, ov=1. Then a=6, b=2 → ov=0.

Source files
------------

// File: rtl/sub4_serial.sv
// Bit-serial subtractor d = a - b - bi, LSB first, one full-subtractor cell per clock.
// Optional SUB_OVF_EN adds a registered signed-overflow output ov.
module sub4_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             busy,
  output logic             done
`ifdef SUB_OVF_EN
  ,
  output logic             ov
`endif
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rd;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             x;
  logic             y;
  logic             diff;
  logic             br_next;
  logic             last;
  logic [WIDTH-1:0] rd_next;

  assign x       = ra[0];
  assign y       = rb[0];
  assign diff    = x ^ y ^ br;
  assign br_next = (~x & y) | (~(x ^ y) & br);
  assign rd_next = {diff, rd[WIDTH-1:1]};
  assign last    = (cnt == CW'(WIDTH - 1));

  assign busy = (state == ST_SHIFT);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ra    <= '0;
      rb    <= '0;
      rd    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      d     <= '0;
      bo    <= 1'b0;
`ifdef SUB_OVF_EN
      ov    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            ra    <= a;
            rb    <= b;
            br    <= bi;
            cnt   <= '0;
            state <= ST_SHIFT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          rd  <= rd_next;
          br  <= br_next;
          cnt <= cnt + 1'b1;
          if (last) begin
            d     <= rd_next;
            bo    <= br_next;
`ifdef SUB_OVF_EN
            // On the final bit x/y are the captured operand MSBs and diff is d's MSB.
            ov    <= (x != y) && (diff != x);
`endif
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub4_serial.sv
// Scoreboard bench for sub4_serial: stimulus pushes expected results, a monitor pops on done.
// Build with +define+SUB_OVF_EN to also exercise the ov output.
module tb_sub4_serial;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bi;
  logic [W-1:0] d;
  logic         bo;
  logic         busy;
  logic         done;
`ifdef SUB_OVF_EN
  logic         ov;
`endif

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   busy_cnt = 0;

  sub4_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bi    (bi),
    .d     (d),
    .bo    (bo),
    .busy  (busy),
    .done  (done)
`ifdef SUB_OVF_EN
    ,
    .ov    (ov)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Called at a negedge right before the accepting posedge.
  task automatic push_exp(input logic [W-1:0] ed, input logic eb, input logic eo);
    exp_t e;
    e.d   = ed;
    e.bo  = eb;
    e.ov  = eo;
    e.cyc = cyc + 1 + W;
    exp_q.push_back(e);
  endtask

  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbi,
                        input logic [W-1:0] ed, input logic eb, input logic eo,
                        input bit glitch);
    @(negedge clk);
    a = va; b = vb; bi = vbi; start = 1'b1;
    push_exp(ed, eb, eo);
    @(negedge clk);
    start = 1'b0;
    a = ~va; b = ~vb; bi = ~vbi;
    @(negedge clk);
    start = glitch;
    @(negedge clk);
    start = 1'b0;
    repeat (W) @(negedge clk);
  endtask

  // Monitor: pops one expected entry per done pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("txn: d=%0d bo=%0d at cycle %0d (expect d=%0d bo=%0d cycle %0d)",
                   d, bo, cyc, e.d, e.bo, e.cyc);
          check("d", int'(d), int'(e.d));
          check("bo", int'(bo), int'(e.bo));
`ifdef SUB_OVF_EN
          check("ov", int'(ov), int'(e.ov));
`endif
          check("done_cycle", cyc, e.cyc);
          check("busy_cycles", busy_cnt, W);
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a = '0; b = '0; bi = 1'b0;
    @(negedge clk);
    check("rst_d", int'(d), 0);
    check("rst_bo", int'(bo), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 1'b1, 1'b0);
    run_op(4'd3, 4'd9, 1'b1, 4'd9, 1'b1, 1'b1, 1'b1);   // with start glitch mid-shift
    run_op(4'd0, 4'd0, 1'b1, 4'd15, 1'b1, 1'b0, 1'b0);
    run_op(4'd15, 4'd15, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Back-to-back: start held, second operands presented on the DONE cycle.
    @(negedge clk);
    a = 4'd5; b = 4'd2; bi = 1'b0; start = 1'b1;
    push_exp(4'd3, 1'b0, 1'b0);
    repeat (W + 1) @(negedge clk);
    a = 4'd2; b = 4'd5; bi = 1'b0;
    push_exp(4'd13, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (W + 2) @(negedge clk);

    // Reset aborts an operation on its 2nd SHIFT cycle.
    a = 4'd12; b = 4'd4; bi = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_abort_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort_d", int'(d), 0);
    check("abort_bo", int'(bo), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 3) @(negedge clk);

    run_op(4'd12, 4'd4, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0);

`ifdef SUB_OVF_EN
    run_op(4'd7, 4'd8, 1'b0, 4'd15, 1'b1, 1'b1, 1'b0);
    run_op(4'd8, 4'd1, 1'b0, 4'd7, 1'b0, 1'b1, 1'b0);
    run_op(4'd6, 4'd2, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0);
`endif

    repeat (2 * W) @(negedge clk);
    check("pending_results", exp_q.size(), 0);
    check("idle_busy", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
